// File: rtl/lvds_deframer.sv
// Three-lane LVDS receive deframer: assembles strobed dibits into bytes,
// decodes header/payload pairs and pulses the payload onto one channel.
//
// Ports:
//   clk        sole clock, lanes sampled on the rising edge
//   arst       synchronous active-high reset
//   lane_data  [2] byte strobe, [1:0] data dibit (MSB dibit first)
//   ch_data    last delivered payload byte (held between pulses)
//   ch_valid   one-hot single-cycle pulse qualifying ch_data
//   sync_err   single-cycle pulse: strobe seen mid-byte
//   hdr_err    single-cycle pulse: invalid header byte
//   err_count  saturating count of error cycles
module lvds_deframer #(
    parameter int          CH_COUNT = 3,
    parameter logic [3:0]  HDR_MARK = 4'hA
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [2:0]          lane_data,
    output logic [7:0]          ch_data,
    output logic [CH_COUNT-1:0] ch_valid,
    output logic                sync_err,
    output logic                hdr_err,
    output logic [7:0]          err_count
);

    typedef enum logic {
        WAIT_HDR = 1'b0,
        WAIT_PAY = 1'b1
    } state_t;

    localparam logic [CH_COUNT-1:0] CH_ONE =
        {{(CH_COUNT-1){1'b0}}, 1'b1};

    logic       strobe;
    logic [1:0] dibit;

    assign strobe = lane_data[2];
    assign dibit  = lane_data[1:0];

    // Byte assembly state. cnt_q is the index of the next
    // expected dibit; idle_q means no byte is in progress.
    logic       idle_q,  idle_d;
    logic [1:0] cnt_q,   cnt_d;
    logic [5:0] shift_q, shift_d;
    logic [7:0] byte_q,  byte_d;
    logic       bvld_q,  bvld_d;
    logic       sync_d;

    // Frame decode and output state.
    state_t              state_q,    state_d;
    logic [1:0]          ch_q,       ch_d;
    logic [7:0]          ch_data_q,  ch_data_d;
    logic [CH_COUNT-1:0] ch_valid_q, ch_valid_d;
    logic                sync_err_q;
    logic                hdr_err_q,  hdr_err_d;
    logic [7:0]          err_q,      err_d;
    logic                hdr_ok;

    always_comb begin
        idle_d  = idle_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        bvld_d  = 1'b0;
        sync_d  = 1'b0;
        if (strobe) begin
            // A strobe always starts a fresh byte; when it lands on
            // a partially filled byte that byte is dropped.
            sync_d  = !idle_q && (cnt_q != 2'd0);
            shift_d = {4'b0000, dibit};
            cnt_d   = 2'd1;
            idle_d  = 1'b0;
        end else if (!idle_q) begin
            shift_d = {shift_q[3:0], dibit};
            if (cnt_q == 2'd3) begin
                byte_d = {shift_q, dibit};
                bvld_d = 1'b1;
                idle_d = 1'b1;
                cnt_d  = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    assign hdr_ok = (byte_q[7:4] == HDR_MARK) &&
                    (32'(byte_q[1:0]) < CH_COUNT);

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        ch_data_d  = ch_data_q;
        ch_valid_d = '0;
        hdr_err_d  = 1'b0;
        if (bvld_q) begin
            unique case (state_q)
                WAIT_HDR: begin
                    if (hdr_ok) begin
                        ch_d    = byte_q[1:0];
                        state_d = WAIT_PAY;
                    end else begin
                        hdr_err_d = 1'b1;
                    end
                end
                WAIT_PAY: begin
                    ch_data_d  = byte_q;
                    ch_valid_d = CH_ONE << ch_q;
                    state_d    = WAIT_HDR;
                end
                default: state_d = WAIT_HDR;
            endcase
        end
        // A resync means the next byte is a header.
        if (sync_d) begin
            state_d = WAIT_HDR;
        end
    end

    // Both error sources count as one per cycle.
    always_comb begin
        err_d = err_q;
        if ((sync_d || hdr_err_d) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            idle_q     <= 1'b1;
            cnt_q      <= 2'd0;
            shift_q    <= 6'd0;
            byte_q     <= 8'd0;
            bvld_q     <= 1'b0;
            state_q    <= WAIT_HDR;
            ch_q       <= 2'd0;
            ch_data_q  <= 8'd0;
            ch_valid_q <= '0;
            sync_err_q <= 1'b0;
            hdr_err_q  <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            idle_q     <= idle_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            bvld_q     <= bvld_d;
            state_q    <= state_d;
            ch_q       <= ch_d;
            ch_data_q  <= ch_data_d;
            ch_valid_q <= ch_valid_d;
            sync_err_q <= sync_d;
            hdr_err_q  <= hdr_err_d;
            err_q      <= err_d;
        end
    end

    assign ch_data   = ch_data_q;
    assign ch_valid  = ch_valid_q;
    assign sync_err  = sync_err_q;
    assign hdr_err   = hdr_err_q;
    assign err_count = err_q;

endmodule
